spi_bundle_unpacker: RTL

Downstream stage of the four-channel SPI byte multiplexer. It accepts the 40-bit channel bundle (four byte lanes plus per-lane valid flags), buffers bundles in a small FIFO, and serializes each bundle into a channel-tagged byte stream with a valid/ready handshake. It feeds per-byte consumers such as the feature/frame assembler. The multiplexer does not honour backpressure, so this block absorbs bursts and flags any loss instead of stalling its source.

---
 rtl/spi_bundle_unpacker_if.sv | 26 ++
 rtl/spi_bundle_unpacker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_bundle_unpacker_if.sv
// Bundle-in / tagged-byte-out bus for spi_bundle_unpacker.
// The master drives bundles and out_ready. The slave (the unpacker) drives
// the byte stream and the status outputs.
interface spi_bundle_unpacker_if #(
  parameter int unsigned DEPTH = 4
);
  logic [39:0]            in_dout;
  logic                   in_ivalid;
  logic                   in_ready;
  logic [7:0]             out_data;
  logic [1:0]             out_chan;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output in_dout, in_ivalid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, overflow, level
  );

  modport slave (
    input  in_dout, in_ivalid, out_ready,
    output in_ready, out_data, out_chan, out_valid, overflow, level
  );
endinterface

// File: rtl/spi_bundle_unpacker.sv
// spi_bundle_unpacker: buffers 4-lane SPI bundles in a small FIFO and
// serializes each bundle into a channel-tagged byte stream.
// The source never stalls. A bundle that arrives when the FIFO is full is
// dropped, and the sticky overflow flag records the loss.
module spi_bundle_unpacker #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  CH_MASK = 4'b1111
) (
  input logic               clk,
  input logic               rst,
  spi_bundle_unpacker_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  // FIFO storage: {flags[3:0], lanes[31:0]}
  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;

  // emitter state
  logic [0:0]    state;
  logic [31:0]   cur_data;
  logic [3:0]    pend;
  logic [7:0]    out_data_q;
  logic [1:0]    out_chan_q;
  logic          out_valid_q;
  logic          overflow_q;

  logic [3:0]    flags;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          fire;
  logic          pop;
  logic [3:0]    pend_left;
  logic [35:0]   head;
  logic          unused_hi;

  // index of the lowest set lane flag (ascending channel order)
  function automatic logic [1:0] low_idx(input logic [3:0] m);
    low_idx = 2'd0;
    if (m[0])      low_idx = 2'd0;
    else if (m[1]) low_idx = 2'd1;
    else if (m[2]) low_idx = 2'd2;
    else if (m[3]) low_idx = 2'd3;
  endfunction

  // byte lane selector
  function automatic logic [7:0] lane(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    lane = d[7:0];
      2'd1:    lane = d[15:8];
      2'd2:    lane = d[23:16];
      default: lane = d[31:24];
    endcase
  endfunction

  // Upper four bundle bits carry nothing for this stage.
  assign unused_hi = ^bus.in_dout[39:36];

  // FIFO status and handshake decode
  always_comb begin
    flags     = bus.in_dout[35:32] & CH_MASK;
    full      = (level_q == DEPTH_L);
    empty     = (level_q == '0);
    // Writes are gated on full only. A pop in the same cycle does not free a slot.
    push      = bus.in_ivalid && (flags != '0) && !full;
    drop      = bus.in_ivalid && (flags != '0) && full;
    fire      = out_valid_q && bus.out_ready;
    pend_left = pend & ~(4'b0001 << out_chan_q);
    head      = mem[rd_ptr];
    // Pop when idle, or when the last byte of the current bundle is accepted (no bubble).
    if (state == EMPTY) pop = !empty;
    else                pop = fire && (pend_left == '0) && !empty;
  end

  // FIFO storage write (data array needs no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {flags, bus.in_dout[31:0]};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // sticky loss flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  // emitter: load a bundle, then walk its pending mask lowest lane first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      cur_data    <= '0;
      pend        <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (pop) begin
      cur_data    <= head[31:0];
      pend        <= head[35:32];
      out_chan_q  <= low_idx(head[35:32]);
      out_data_q  <= lane(head[31:0], low_idx(head[35:32]));
      out_valid_q <= 1'b1;
      state       <= EMIT;
    end else if (state == EMIT && fire) begin
      if (pend_left != '0) begin
        pend       <= pend_left;
        out_chan_q <= low_idx(pend_left);
        out_data_q <= lane(cur_data, low_idx(pend_left));
      end else begin
        pend        <= '0;
        out_valid_q <= 1'b0;
        state       <= EMPTY;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.level     = level_q;

endmodule
